// File: rtl/grf_write_tracer.sv
// grf_write_tracer: passive snoop of committed GRF writes into a show-ahead
// FIFO that drains through a valid/ready trace stream. Never back-pressures
// the pipeline; writes arriving while full are discarded and counted.
module grf_write_tracer #(
    parameter int unsigned DEPTH     = 8,
    parameter bit          DROP_ZERO = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     WEn,
    input  logic [4:0]               AddrW,
    input  logic [31:0]              WData,
    input  logic [31:0]              PC,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [4:0]               trace_addr,
    output logic [31:0]              trace_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [31:0]      pc_mem_q   [DEPTH];
    logic [4:0]       addr_mem_q [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;

    logic             empty_c, full_c, push_c, pop_c, write_c, drop_c;

    // Occupancy flags, handshake decode and next-state of pointers/counters
    always_comb begin
        empty_c    = (wr_ptr_q == rd_ptr_q);
        full_c     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop_c      = !empty_c && trace_ready;
        push_c     = WEn && !(DROP_ZERO && (AddrW == 5'd0));
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        write_c    = push_c && (!full_c || pop_c);
        drop_c     = push_c && full_c && !pop_c;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;

        if (write_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (drop_c) begin
            overflow_d = 1'b1;
            if (dropped_q != {CNT_W{1'b1}}) begin
                dropped_d = dropped_q + CNT_W'(1);
            end
        end
    end

    // Pointer and loss-tracking registers; reset overrides any push/pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Entry storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (reset && write_c) begin
            pc_mem_q[wr_ptr_q[AW-1:0]]   <= PC;
            addr_mem_q[wr_ptr_q[AW-1:0]] <= AddrW;
            data_mem_q[wr_ptr_q[AW-1:0]] <= WData;
        end
    end

    // Show-ahead head, forced to zero while empty
    always_comb begin
        trace_valid = !empty_c;
        trace_pc    = '0;
        trace_addr  = '0;
        trace_data  = '0;
        if (!empty_c) begin
            trace_pc   = pc_mem_q[rd_ptr_q[AW-1:0]];
            trace_addr = addr_mem_q[rd_ptr_q[AW-1:0]];
            trace_data = data_mem_q[rd_ptr_q[AW-1:0]];
        end
        level    = wr_ptr_q - rd_ptr_q;
        overflow = overflow_q;
        dropped  = dropped_q;
    end

endmodule

// File: tb/tb_grf_write_tracer.sv
// Bench for grf_write_tracer: directed steps with a queue scoreboard of
// expected trace entries plus a reference model of overflow/dropped.
module tb_grf_write_tracer;

    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        WEn;
    logic [4:0]  AddrW;
    logic [31:0] WData;
    logic [31:0] PC;
    logic        trace_ready;

    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] dropped;

    logic        b_valid;
    logic [31:0] b_pc;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [3:0]  b_level;
    logic        b_overflow;
    logic [1:0]  b_dropped;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        sb[$];
    logic        exp_ovf;
    logic [15:0] exp_drop;
    int          n_cmp;
    int          n_err;

    grf_write_tracer #(.DEPTH(DEPTH), .DROP_ZERO(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .WEn(WEn), .AddrW(AddrW), .WData(WData),
        .PC(PC), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .level(level), .overflow(overflow), .dropped(dropped)
    );

    // Second instance: records $0 writes and has a tiny saturating counter
    grf_write_tracer #(.DEPTH(DEPTH), .DROP_ZERO(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .WEn(WEn), .AddrW(AddrW), .WData(WData),
        .PC(PC), .trace_valid(b_valid), .trace_ready(trace_ready),
        .trace_pc(b_pc), .trace_addr(b_addr), .trace_data(b_data),
        .level(b_level), .overflow(b_overflow), .dropped(b_dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge with no checks (used only before the first reset has landed)
    task automatic raw_edge();
        @(posedge clk);
        #1;
    endtask

    // Check outputs against the model, advance one edge, update the model
    task automatic tick();
        bit do_pop;
        bit do_push;
        bit exp_v;
        exp_v = (sb.size() != 0);
        chk("valid", 32'(trace_valid), 32'(exp_v));
        chk("level", 32'(level), 32'(sb.size()));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("dropped", 32'(dropped), 32'(exp_drop));
        if (exp_v) begin
            chk("head_pc", trace_pc, sb[0].pc);
            chk("head_addr", 32'(trace_addr), 32'(sb[0].addr));
            chk("head_data", trace_data, sb[0].data);
        end else begin
            chk("empty_pc", trace_pc, 32'd0);
            chk("empty_addr", 32'(trace_addr), 32'd0);
            chk("empty_data", trace_data, 32'd0);
        end
        do_pop  = exp_v && trace_ready;
        do_push = WEn && (AddrW != 5'd0);
        @(posedge clk);
        if (!reset) begin
            sb.delete();
            exp_ovf  = 1'b0;
            exp_drop = '0;
        end else begin
            if (do_push) begin
                if (sb.size() < DEPTH || do_pop) begin
                    sb.push_back('{pc: PC, addr: AddrW, data: WData});
                end else begin
                    exp_ovf = 1'b1;
                    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
                end
            end
            if (do_pop) void'(sb.pop_front());
        end
        #1;
    endtask

    task automatic write(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        WEn   = 1'b1;
        PC    = pc;
        AddrW = a;
        WData = d;
        tick();
        WEn   = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_ovf  = 1'b0;
        exp_drop = '0;
        reset       = 1'b0;
        WEn         = 1'b1;
        AddrW       = 5'd5;
        WData       = 32'hDEAD;
        PC          = 32'h100;
        trace_ready = 1'b0;

        // Reset held with a write pending
        raw_edge();
        raw_edge();
        reset = 1'b1;
        WEn   = 1'b0;
        tick();

        // Single write, held while not ready, then drained
        write(32'h3000, 5'd1, 32'd15);
        chk("single_pc", trace_pc, 32'h3000);
        chk("single_data", trace_data, 32'd15);
        repeat (3) tick();
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        tick();

        // $0 write: filtered by main instance, recorded by the other
        write(32'h3004, 5'd0, 32'd22);
        chk("b_zero_valid", 32'(b_valid), 32'd1);
        chk("b_zero_addr", 32'(b_addr), 32'd0);
        chk("b_zero_data", b_data, 32'd22);
        chk("b_zero_level", 32'(b_level), 32'd1);
        tick();
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;

        // Overflow: 10 writes into 8 slots
        for (int i = 1; i <= 10; i++) write(32'h4000 + 32'(4 * i), 5'd2, 32'(i));
        tick();
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_dropped", 32'(dropped), 32'd2);
        trace_ready = 1'b1;
        repeat (9) tick();
        trace_ready = 1'b0;

        // Full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) write(32'h5000 + 32'(4 * i), 5'd3, 32'(i));
        trace_ready = 1'b1;
        write(32'h5024, 5'd3, 32'd9);
        trace_ready = 1'b0;
        tick();
        chk("fullpp_level", 32'(level), 32'd8);
        chk("fullpp_dropped", 32'(dropped), 32'd2);
        trace_ready = 1'b1;
        repeat (9) tick();
        trace_ready = 1'b0;

        // Further overflow: second instance's 2-bit counter saturates
        for (int i = 0; i < 11; i++) write(32'h6000 + 32'(4 * i), 5'd4, 32'(50 + i));
        tick();
        chk("b_sat_dropped", 32'(b_dropped), 32'd3);
        chk("b_sat_overflow", 32'(b_overflow), 32'd1);
        chk("sat_dropped", 32'(dropped), 32'd5);
        trace_ready = 1'b1;
        repeat (9) tick();

        // Streaming with pointer wrap
        for (int i = 0; i < 20; i++) write(32'h7000 + 32'(4 * i), 5'(1 + i % 31), 32'(100 + i));
        tick();
        tick();

        // Mid-run reset with entries queued
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) write(32'h8000 + 32'(4 * i), 5'd7, 32'(200 + i));
        chk("pre_rst_level", 32'(level), 32'd3);
        reset = 1'b0;
        WEn   = 1'b1;
        tick();
        reset = 1'b1;
        WEn   = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        chk("rst_b_dropped", 32'(b_dropped), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
